input_debounce: RTL
===================

// Module: input_debounce
// PURPOSE
//  Consumes the 21-bit vector from the switch/button deserializer: bits [15:0] are DIP
//  switches and bits [20:16] are push buttons. It takes one coherent snapshot per serial
//  frame and debounces each bit across frames. It emits clean levels, one-cycle
//  press/release pulses, and a frame-loss error flag to the application logic.
// PARAMETERS
//  WIDTH            21  number of input bits
//  DEBOUNCE_FRAMES   4  consecutive differing frames needed to flip a stable bit (>=1)
//  TIMEOUT_CYCLES   64  cycles without a frame start before link_err asserts (>=2)
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst         in   1      asynchronous, active-high reset
//  raw         in   WIDTH  parallel vector from deserializer; bits update one per cycle
//  frame_sync  in   1      deserializer latch; low for 1 cycle per frame = frame start
//  stable      out  WIDTH  debounced levels
//  press       out  WIDTH  1-cycle pulse per bit on a stable 0->1 transition
//  release     out  WIDTH  1-cycle pulse per bit on a stable 1->0 transition
//  frame_tick  out  1      1-cycle pulse each time a snapshot has been processed
//  valid       out  1      high once the first frame after reset has been processed
//  link_err    out  1      no frame start seen for TIMEOUT_CYCLES cycles
// BEHAVIOUR
//  - Reset (async assert): all outputs 0, all counters 0, snapshot 0.
//    sync_q (previous frame_sync) resets to 1, so a low in the first cycle counts as a frame.
//  - Frame start: frame_sync==0 && sync_q==1. A low run of any length counts as one frame.
//  - Edge E (frame start): snap <= raw. This is the pre-edge value, i.e. the completed frame.
//    Changes on raw at any other time are ignored.
//  - Edge E+1 (processing), first frame after reset:
//    stable <= snap; valid <= 1; no press/release pulses; counters 0.
//  - Edge E+1, later frames, per bit i:
//    - snap[i]==stable[i] -> cnt[i] <= 0.
//    - else if cnt[i]==DEBOUNCE_FRAMES-1 -> stable[i] <= snap[i]; cnt[i] <= 0;
//      press[i] or release[i] <= 1.
//    - else cnt[i] <= cnt[i]+1.
//  - press, release and frame_tick are registered at E+1 and high exactly one cycle.
//    They are 0 in all other cycles.
//  - frame_tick <= 1 at every E+1, including the first frame.
//  - Latency: a bit differing on N consecutive snapshots flips stable at E+1 of the Nth frame.
//    DEBOUNCE_FRAMES=1 gives an immediate update.
//  - Counter width is clog2(DEBOUNCE_FRAMES+1). cnt never exceeds DEBOUNCE_FRAMES-1.
//  - Frame start during the E+1 processing cycle cannot occur (frame_sync needs a high
//    cycle first). Back-to-back processing is nevertheless handled, since snap is stable
//    from E to E+1.
//  - Watchdog: wd counts cycles since the last frame start and saturates at TIMEOUT_CYCLES.
//    - Frame start sets wd <= 0 and link_err <= 0.
//    - link_err <= 1 when wd reaches TIMEOUT_CYCLES-1 and no frame start occurs that cycle.
//    - link_err is held until the next frame start.
//    - stable, valid and counters are untouched by the watchdog.
//  - Reset mid-debounce discards counters and pending pulses.
//    The next frame is treated as the first frame (no pulses).
// TESTING
//  1. Reset, raw=21'h1ABCD, one frame -> at E+1: stable=21'h1ABCD, valid=1,
//     frame_tick=1, press=0, release=0.
//  2. raw[16] 0->1 held 4 frames -> press[16]=1 for exactly one cycle at E+1 of the 4th
//     frame, stable[16]=1; frames 1-3 show no change.
//  3. raw[3] differs for 3 frames then reverts -> stable[3] unchanged, no pulses;
//     a further 3 differing frames still produce no flip (counter was cleared).
//  4. raw toggled every cycle while frame_sync=1, settled before the frame start ->
//     only the value at edge E is captured, and intermediate values have no effect.
//  5. frame_sync held 1 for 64 cycles -> link_err=1 from cycle 64; one low cycle clears it
//     on that edge; stable stays constant throughout.
//  6. frame_sync low for 3 consecutive cycles -> one frame_tick only.
//     Assert rst mid-debounce -> all outputs 0 at once, and the next frame loads stable
//     with no press.

Source files
------------

// File: rtl/input_debounce.sv
// Frame-synchronous debouncer for the switch/button deserializer vector.
// One snapshot is taken per serial frame; each bit is debounced across frames.
// The release pulse output is named release_pulse because "release" is a
// reserved SystemVerilog keyword.

// Per-bit debounce: consecutive-differing-frame counter plus stable level.
module debounce_bit #(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic proc,    // processing cycle (E+1)
  input  logic first,   // first frame since reset: load directly
  input  logic snap,
  output logic stable,
  output logic press,
  output logic rel
);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  // Next-state: count frames that disagree with the stable level, flip on the last one
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    if (proc) begin
      if (first) begin
        stable_d = snap;
        cnt_d    = '0;
      end else if (snap == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        stable_d = snap;
        cnt_d    = '0;
        press_d  = snap;
        rel_d    = ~snap;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;
  assign rel    = rel_q;
endmodule

module input_debounce #(
  parameter int WIDTH           = 21,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic             frame_tick,
  output logic             valid,
  output logic             link_err
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_TRIP = WW'(TIMEOUT_CYCLES - 1);

  logic             sync_q, sync_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             proc_q, proc_d;
  logic             valid_q, valid_d;
  logic             tick_q, tick_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic             link_err_q, link_err_d;
  logic             frame_start;
  logic             first_frame;

  // Frame capture, processing strobe and link watchdog next-state
  always_comb begin
    frame_start = ~frame_sync & sync_q;
    sync_d      = frame_sync;
    snap_d      = frame_start ? raw : snap_q;
    proc_d      = frame_start;
    tick_d      = proc_q;
    valid_d     = valid_q | proc_q;
    wd_d        = wd_q;
    link_err_d  = link_err_q;
    if (frame_start) begin
      wd_d       = '0;
      link_err_d = 1'b0;
    end else begin
      if (wd_q != WD_MAX) wd_d = wd_q + WW'(1);
      if (wd_q == WD_TRIP) link_err_d = 1'b1;
    end
  end

  // Frame-level registers; sync_q resets high so a low first cycle is a frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 1'b1;
      snap_q     <= '0;
      proc_q     <= 1'b0;
      valid_q    <= 1'b0;
      tick_q     <= 1'b0;
      wd_q       <= '0;
      link_err_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      snap_q     <= snap_d;
      proc_q     <= proc_d;
      valid_q    <= valid_d;
      tick_q     <= tick_d;
      wd_q       <= wd_d;
      link_err_q <= link_err_d;
    end
  end

  assign first_frame = ~valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_bit (
      .clk    (clk),
      .rst    (rst),
      .proc   (proc_q),
      .first  (first_frame),
      .snap   (snap_q[i]),
      .stable (stable[i]),
      .press  (press[i]),
      .rel    (release_pulse[i])
    );
  end

  assign frame_tick = tick_q;
  assign valid      = valid_q;
  assign link_err   = link_err_q;
endmodule
